bp_coherence_network_rx_endpoint: RTL
=====================================

// Module: bp_coherence_network_rx_endpoint
//
// PURPOSE
//  Destination-side endpoint for one Proc port of the coherence network channel.
//  It accepts packets under the ready-then-valid (demanding producer) protocol.
//  It buffers them in a small FIFO and re-presents them to the local LCE/CCE over valid->ready.
//  It tracks delivered-packet count and sticky protocol errors.
//  One instance sits per network destination, between the router P output and the consumer.
//
// PARAMETERS
//  packet_width_p  "inv"  packet width; the dst id occupies the top lg_num_dst bits
//  num_dst_p       "inv"  destinations on the channel; lg_num_dst = `BSG_SAFE_CLOG2(num_dst_p)
//  fifo_els_p      2      buffer depth; must be >= 2
//  count_width_p   16     width of the delivered-packet counter
//
// PORTS
//  clk_i          in   1               clock
//  reset_n_i      in   1               async active-low reset
//  my_id_i        in   lg_num_dst      this endpoint's destination id; static after reset
//  net_data_i     in   packet_width_p  packet from the network P port
//  net_v_i        in   1               packet valid; producer asserts only when net_ready_o is high
//  net_ready_o    out  1               endpoint guarantees acceptance this cycle
//  data_o         out  packet_width_p  head packet to the consumer
//  v_o            out  1               head valid
//  ready_i        in   1               consumer ready; transfer = v_o & ready_i
//  err_clr_i      in   1               clears err_o
//  err_o          out  2               sticky: [0] overflow, [1] dst id mismatch
//  pkt_count_o    out  count_width_p   packets dequeued to the consumer; saturating
//
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the system): occupancy=0, rd/wr pointers=0,
//    net_ready_o=0, v_o=0, err_o=0, pkt_count_o=0. Buffer contents are don't-care.
//    Reset mid-operation discards every buffered packet.
//  - net_ready_o is a register: next = (occ_next < fifo_els_p). First cycle after reset: 1.
//    It never depends combinationally on ready_i or net_v_i.
//  - Enqueue: net_v_i & net_ready_o (and id accepted, see CONFIGURATION).
//    Data is written at wr_ptr, which then wraps mod fifo_els_p.
//  - net_v_i while net_ready_o=0 is a protocol violation: the packet is dropped,
//    err_o[0] is set, and state is otherwise unchanged.
//  - Dequeue: v_o & ready_i. rd_ptr wraps mod fifo_els_p.
//    pkt_count_o += 1, saturating at all-ones.
//  - v_o = (occ != 0); data_o = mem[rd_ptr]. Minimum latency: net_v_i in cycle t -> v_o in t+1.
//  - Simultaneous enqueue and dequeue: occupancy is unchanged and both pointers advance.
//    Bypassing an empty FIFO in the same cycle is not allowed.
//  - Full buffer: net_ready_o=0 in the cycle after the fill. If the consumer dequeues
//    at full, net_ready_o returns to 1 the next cycle.
//  - Sustained throughput: 1 pkt/cycle when ready_i is held high and fifo_els_p >= 2.
//  - err_o bits are sticky until err_clr_i. If a set and err_clr_i land in the same cycle, the set wins.
//  - data_o and v_o are stable while v_o & ~ready_i.
//
// CONFIGURATION
//  BP_ME_NET_RX_ID_CHECK_EN
//   defined: dst_id = net_data_i[packet_width_p-1 -: lg_num_dst] is compared to my_id_i.
//     On a mismatch with net_v_i & net_ready_o, the packet is not enqueued and err_o[1] is set.
//     A mismatch arriving together with a protocol violation sets both bits.
//   undefined: no comparison is made, every accepted packet is enqueued,
//     and err_o[1] is tied to 0.
//
// TESTING
//  1. Reset release, fifo_els_p=2: net_ready_o=0 during reset and 1 on the first clk after it;
//     v_o=0 and pkt_count_o=0 throughout.
//  2. Send A5, 3C, 7F back-to-back with ready_i=1: v_o rises 1 cycle after A5.
//     data_o yields A5, 3C, 7F in order, then pkt_count_o=3.
//  3. ready_i=0, send 2 packets: net_ready_o=0 after the 2nd packet, data_o holds the 1st.
//     Raise ready_i for 1 cycle: net_ready_o=1 the next cycle, occupancy=1.
//  4. Force net_v_i=1 while net_ready_o=0: the packet is dropped, err_o=2'b01, and the FIFO is unchanged.
//     Pulse err_clr_i: err_o=0.
//  5. With ID_CHECK_EN, my_id_i=1, send a packet with dst_id=0: not delivered, err_o[1]=1.
//     A packet with dst_id=1 is delivered. Without the macro, both are delivered and err_o=0.
//  6. Assert reset_n_i=0 with 2 packets buffered: v_o=0 and pkt_count_o=0 immediately.
//     No stale packet appears after reset is released.

Source files
------------

// File: rtl/bp_coherence_network_rx_endpoint.sv
// bp_coherence_network_rx_endpoint
//   Destination-side endpoint for one Proc port of the coherence network.
//   Packets come in under ready-then-valid (the producer only asserts net_v_i
//   while net_ready_o is high). They are buffered in a small FIFO and handed to
//   the local LCE/CCE over valid->ready. The block also keeps a saturating
//   count of delivered packets and sticky protocol-error flags.
//
// Ports
//   clk_i, reset_n_i    clock, async active-low reset
//   my_id_i             this endpoint's destination id (static after reset)
//   net_data_i/net_v_i  packet from the router P port
//   net_ready_o         registered; high means a packet is accepted this cycle
//   data_o/v_o/ready_i  head packet to the consumer, transfer = v_o & ready_i
//   err_clr_i           clears err_o
//   err_o               sticky: [0] overflow, [1] dst id mismatch
//   pkt_count_o         packets dequeued to the consumer, saturating
//
// Configuration
//   BP_ME_NET_RX_ID_CHECK_EN  when defined, the dst id in the top bits of the
//                             packet is compared to my_id_i and mismatching
//                             packets are dropped with err_o[1] set.

module bp_coherence_network_rx_endpoint #(
  parameter int packet_width_p = 8,
  parameter int num_dst_p      = 4,
  parameter int fifo_els_p     = 2,
  parameter int count_width_p  = 16,
  parameter int lg_num_dst_lp  = (num_dst_p > 1) ? $clog2(num_dst_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [lg_num_dst_lp-1:0]  my_id_i,
  input  logic [packet_width_p-1:0] net_data_i,
  input  logic                      net_v_i,
  output logic                      net_ready_o,
  output logic [packet_width_p-1:0] data_o,
  output logic                      v_o,
  input  logic                      ready_i,
  input  logic                      err_clr_i,
  output logic [1:0]                err_o,
  output logic [count_width_p-1:0]  pkt_count_o
);

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int occ_w_lp = $clog2(fifo_els_p + 1);

  logic [packet_width_p-1:0] r_mem [fifo_els_p];
  logic [ptr_w_lp-1:0]       r_wr_ptr, r_rd_ptr;
  logic [occ_w_lp-1:0]       r_occ;
  logic                      r_net_ready;
  logic [1:0]                r_err;
  logic [count_width_p-1:0]  r_pkt_count;

  logic                      w_id_ok;
  logic                      w_id_err;
  logic                      w_viol;
  logic                      w_enq;
  logic                      w_deq;
  logic [occ_w_lp-1:0]       w_occ_next;
  logic [1:0]                w_err_set;

`ifdef BP_ME_NET_RX_ID_CHECK_EN
  assign w_id_ok  = (net_data_i[packet_width_p-1 -: lg_num_dst_lp] == my_id_i);
  // Flagged whether or not the packet was also a protocol violation.
  assign w_id_err = net_v_i & ~w_id_ok;
`else
  logic w_unused_id;
  assign w_unused_id = ^my_id_i;
  assign w_id_ok     = 1'b1;
  assign w_id_err    = 1'b0;
`endif

  assign w_viol    = net_v_i & ~r_net_ready;
  assign w_enq     = net_v_i & r_net_ready & w_id_ok;
  assign w_deq     = (r_occ != '0) & ready_i;
  assign w_err_set = {w_id_err, w_viol};

  always_comb begin
    w_occ_next = r_occ;
    if (w_enq && !w_deq)      w_occ_next = r_occ + 1'b1;
    else if (!w_enq && w_deq) w_occ_next = r_occ - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_net_ready <= 1'b0;
      r_err       <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_enq)
        r_wr_ptr <= (r_wr_ptr == ptr_w_lp'(fifo_els_p - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_deq) begin
        r_rd_ptr <= (r_rd_ptr == ptr_w_lp'(fifo_els_p - 1)) ? '0 : r_rd_ptr + 1'b1;
        if (r_pkt_count != '1)
          r_pkt_count <= r_pkt_count + 1'b1;
      end
      r_occ       <= w_occ_next;
      // Registered so acceptance never depends combinationally on the consumer.
      r_net_ready <= (w_occ_next < occ_w_lp'(fifo_els_p));
      // Set takes priority over clear.
      r_err       <= (r_err & ~{2{err_clr_i}}) | w_err_set;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (w_enq)
      r_mem[r_wr_ptr] <= net_data_i;
  end

  assign net_ready_o = r_net_ready;
  assign v_o         = (r_occ != '0);
  assign data_o      = r_mem[r_rd_ptr];
  assign err_o       = r_err;
  assign pkt_count_o = r_pkt_count;

endmodule
